// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed byte stream, packs bytes little-endian into 32-bit words,
// writes them to instruction memory and releases the core only after the XOR checksum matches.
module imem_loader #(
   parameter int unsigned ADDR_WIDTH = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic [7:0]            rx_data_i,
   input  logic                  rx_valid_i,
   output logic                  rx_ready_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [31:0]           mem_wdata_o,
   output logic                  core_reset_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  error_o,
   output logic [ADDR_WIDTH:0]   words_loaded_o
);

   localparam int unsigned MaxWords = 2 ** ADDR_WIDTH;

   typedef enum logic [2:0] {
      StIdle,
      StLenLo,
      StLenHi,
      StData,
      StWrite,
      StCsum,
      StDone,
      StError
   } state_e;

   state_e                state_q, state_d;
   logic [15:0]           len_q, len_d;
   logic [1:0]            idx_q, idx_d;
   logic [7:0]            csum_q, csum_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH:0]   words_q, words_d;
   logic [15:0]           len_full;
   logic                  accept;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         len_q   <= '0;
         idx_q   <= '0;
         csum_q  <= '0;
         wdata_q <= '0;
         addr_q  <= '0;
         words_q <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         csum_q  <= csum_d;
         wdata_q <= wdata_d;
         addr_q  <= addr_d;
         words_q <= words_d;
      end
   end

   always_comb begin
      rx_ready_o = (state_q == StLenLo) || (state_q == StLenHi) ||
                   (state_q == StData)  || (state_q == StCsum);
      accept     = rx_valid_i && rx_ready_o;
   end

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      idx_d    = idx_q;
      csum_d   = csum_q;
      wdata_d  = wdata_q;
      addr_d   = addr_q;
      words_d  = words_q;
      len_full = {rx_data_i, len_q[7:0]};

      unique case (state_q)
         StIdle, StDone, StError: begin
            if (start_i) begin
               state_d = StLenLo;
               words_d = '0;
               csum_d  = '0;
               idx_d   = '0;
               addr_d  = '0;
            end
         end
         StLenLo: begin
            if (accept) begin
               len_d[7:0] = rx_data_i;
               state_d    = StLenHi;
            end
         end
         StLenHi: begin
            if (accept) begin
               len_d = len_full;
               if (len_full == 16'd0 || 32'(len_full) > MaxWords) begin
                  state_d = StError;
               end else begin
                  state_d = StData;
               end
            end
         end
         StData: begin
            if (accept) begin
               wdata_d[{idx_q, 3'b000} +: 8] = rx_data_i;
               csum_d                         = csum_q ^ rx_data_i;
               idx_d                          = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  state_d = StWrite;
               end
            end
         end
         StWrite: begin
            words_d = words_q + 1'b1;
            if (16'(words_q) + 16'd1 == len_q) begin
               // Address is held on the last word so a full-size image cannot wrap to 0.
               state_d = StCsum;
            end else begin
               addr_d  = addr_q + 1'b1;
               state_d = StData;
            end
         end
         StCsum: begin
            if (accept) begin
               state_d = (rx_data_i == csum_q) ? StDone : StError;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      mem_we_o       = (state_q == StWrite);
      mem_addr_o     = addr_q;
      mem_wdata_o    = wdata_q;
      core_reset_o   = (state_q != StDone);
      done_o         = (state_q == StDone);
      error_o        = (state_q == StError);
      busy_o         = (state_q == StLenLo) || (state_q == StLenHi) || (state_q == StData) ||
                       (state_q == StWrite) || (state_q == StCsum);
      words_loaded_o = words_q;
   end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed load scenarios with random payloads and random rx_valid gaps,
// checked against write lists and outcomes derived from the image itself.
module tb_imem_loader;

   localparam int unsigned AW       = 8;
   localparam int unsigned MaxWords = 256;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          core_reset;
   logic          busy;
   logic          done;
   logic          error;
   logic [AW:0]   words_loaded;

   int            n_total = 0;
   int            n_pass  = 0;
   int            ready_in_write = 0;
   logic [AW-1:0] wr_addr_q[$];
   logic [31:0]   wr_data_q[$];
   logic [31:0]   img[$];
   bit            rand_valid = 1'b0;

   imem_loader #(.ADDR_WIDTH(AW)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .start_i        (start),
      .rx_data_i      (rx_data),
      .rx_valid_i     (rx_valid),
      .rx_ready_o     (rx_ready),
      .mem_we_o       (mem_we),
      .mem_addr_o     (mem_addr),
      .mem_wdata_o    (mem_wdata),
      .core_reset_o   (core_reset),
      .busy_o         (busy),
      .done_o         (done),
      .error_o        (error),
      .words_loaded_o (words_loaded)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mem_we) begin
         wr_addr_q.push_back(mem_addr);
         wr_data_q.push_back(mem_wdata);
         if (rx_ready) ready_in_write++;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_rx_ready"},   64'(rx_ready),     64'd0);
      check({tag, "_mem_we"},     64'(mem_we),       64'd0);
      check({tag, "_mem_addr"},   64'(mem_addr),     64'd0);
      check({tag, "_mem_wdata"},  64'(mem_wdata),    64'd0);
      check({tag, "_core_reset"}, 64'(core_reset),   64'd1);
      check({tag, "_busy"},       64'(busy),         64'd0);
      check({tag, "_done"},       64'(done),         64'd0);
      check({tag, "_error"},      64'(error),        64'd0);
      check({tag, "_words"},      64'(words_loaded), 64'd0);
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int cyc = 0;
      bit acc = 1'b0;
      while (!acc && cyc < 200) begin
         @(negedge clk);
         rx_data  = b;
         rx_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
         acc      = rx_valid && rx_ready;
         cyc++;
      end
      if (!acc) check("accept_timeout", 64'(acc), 64'd1);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      rx_valid = 1'b0;
      wr_addr_q.delete();
      wr_data_q.delete();
      ready_in_write = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Streams header, payload from img and checksum; optional start pulse or reset before byte k.
   task automatic send_image(input logic [15:0] len, input bit flip, input int start_at,
                             input int abort_at);
      logic [7:0] cs = 8'h00;
      send_byte(len[7:0]);
      send_byte(len[15:8]);
      if (len == 16'd0 || 32'(len) > MaxWords) begin
         idle(3);
         return;
      end
      for (int i = 0; i < int'(len) * 4; i++) begin
         logic [7:0] b = 8'(img[i / 4] >> (8 * (i % 4)));
         if (i == abort_at) begin
            @(negedge clk);
            rx_valid = 1'b0;
            rst_n    = 1'b0;
            #1;
            reset_checks("midload_reset");
            check("partial_not_written", 64'(wr_addr_q.size()), 64'(i / 4));
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         if (i == start_at) begin
            @(negedge clk);
            rx_valid = 1'b0;
            start    = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("start_in_data_busy", 64'(busy), 64'd1);
         end
         send_byte(b);
         cs ^= b;
      end
      send_byte(cs ^ (flip ? 8'hFF : 8'h00));
      idle(3);
   endtask

   task automatic check_result(input string tag, input logic [15:0] len, input bit flip);
      bit bad_len = (len == 16'd0) || (32'(len) > MaxWords);
      bit ok      = !bad_len && !flip;
      int nw      = bad_len ? 0 : int'(len);
      check({tag, "_nwrites"}, 64'(wr_addr_q.size()), 64'(nw));
      for (int i = 0; i < nw && i < wr_addr_q.size(); i++) begin
         check($sformatf("%s_addr%0d", tag, i), 64'(wr_addr_q[i]), 64'(i));
         check($sformatf("%s_data%0d", tag, i), 64'(wr_data_q[i]), 64'(img[i]));
      end
      check({tag, "_done"},       64'(done),           64'(ok));
      check({tag, "_error"},      64'(error),          64'(!ok));
      check({tag, "_core_reset"}, 64'(core_reset),     64'(!ok));
      check({tag, "_busy"},       64'(busy),           64'd0);
      check({tag, "_words"},      64'(words_loaded),   64'(nw));
      check({tag, "_ready_wr"},   64'(ready_in_write), 64'd0);
   endtask

   task automatic rand_img(input int n);
      img.delete();
      for (int i = 0; i < n; i++) img.push_back($urandom());
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish, want $finish");
      $fatal(1);
   end

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (2) @(negedge clk);
      reset_checks("por");
      rst_n = 1'b1;
      idle(2);

      img = '{32'h00500093, 32'h00000113, 32'h00110133};
      pulse_start();
      send_image(16'd3, 1'b0, -1, -1);
      check_result("t1", 16'd3, 1'b0);

      pulse_start();
      send_image(16'd3, 1'b1, -1, -1);
      check_result("t2", 16'd3, 1'b1);

      pulse_start();
      send_image(16'd0, 1'b0, -1, -1);
      check_result("t3_len0", 16'd0, 1'b0);
      pulse_start();
      send_image(16'd257, 1'b0, -1, -1);
      check_result("t3_len257", 16'd257, 1'b0);

      rand_valid = 1'b1;
      pulse_start();
      send_image(16'd3, 1'b0, -1, -1);
      check_result("t4", 16'd3, 1'b0);
      rand_img(7);
      pulse_start();
      send_image(16'd7, 1'b0, -1, -1);
      check_result("t4_rand", 16'd7, 1'b0);
      rand_valid = 1'b0;

      img = '{32'h00500093, 32'h00000113, 32'h00110133};
      pulse_start();
      send_image(16'd3, 1'b0, -1, 6);
      idle(2);
      reset_checks("after_reset");
      pulse_start();
      send_image(16'd3, 1'b0, -1, -1);
      check_result("t5", 16'd3, 1'b0);

      rand_img(3);
      pulse_start();
      send_image(16'd3, 1'b0, 2, -1);
      check_result("t6_start_data", 16'd3, 1'b0);
      pulse_start();
      check("t6_restart_core_reset", 64'(core_reset), 64'd1);
      check("t6_restart_done",       64'(done),       64'd0);
      check("t6_restart_busy",       64'(busy),       64'd1);
      rand_img(MaxWords);
      send_image(16'(MaxWords), 1'b0, -1, -1);
      check_result("t6_full", 16'(MaxWords), 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
